// File: rtl/uart_result_formatter.sv
// Converts one signed result to ASCII decimal and streams it byte-by-byte to a UART transmitter.
// Build option: define UART_FMT_CRLF_EN to append CR, LF after the digits.
module uart_result_formatter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_DIGITS = 5
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Start,
  input  logic [DATA_WIDTH-1:0] i_Result,
  input  logic                  i_Tx_Active,
  input  logic                  i_Tx_Done,
  output logic                  o_Tx_DV,
  output logic [7:0]            o_Tx_Byte,
  output logic                  o_Busy,
  output logic                  o_Done
);

  localparam int unsigned BcdW = 4 * NUM_DIGITS;
  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
`ifdef UART_FMT_CRLF_EN
  localparam bit CrlfEn = 1'b1;
`else
  localparam bit CrlfEn = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StConvert, StEmit, StWaitDone, StDone} state_e;
  typedef enum logic [1:0] {ItemSign, ItemDigit, ItemCr, ItemLf} item_e;

  state_e            r_state;
  item_e             r_item;
  logic [DATA_WIDTH-1:0] r_mag;
  logic [BcdW-1:0]   r_bcd;
  logic              r_neg;
  logic              r_sig;  // a digit has been sent, so later zeros are significant
  logic [CntW-1:0]   r_cnt;
  logic [IdxW-1:0]   r_idx;

  logic [3:0]        w_digit;
  logic [7:0]        w_byte;
  logic              w_skip;
  logic [BcdW-1:0]   w_bcd_next;

  // One double-dabble step: add 3 to digits >= 5, then shift in the next magnitude bit.
  function automatic logic [BcdW-1:0] dabble(input logic [BcdW-1:0] bcd, input logic bit_in);
    logic [BcdW-1:0] adj;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    return {adj[BcdW-2:0], bit_in};
  endfunction

  always_comb begin
    w_bcd_next = dabble(r_bcd, r_mag[DATA_WIDTH-1]);
    w_digit = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IdxW'(i)) w_digit = r_bcd[4*i +: 4];
    end
    case (r_item)
      ItemSign:  w_byte = 8'h2D;
      ItemDigit: w_byte = 8'h30 + {4'd0, w_digit};
      ItemCr:    w_byte = 8'h0D;
      default:   w_byte = 8'h0A;
    endcase
    w_skip = (r_item == ItemDigit) && !r_sig && (w_digit == 4'd0) && (r_idx != '0);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state   <= StIdle;
      r_item    <= ItemSign;
      r_mag     <= '0;
      r_bcd     <= '0;
      r_neg     <= 1'b0;
      r_sig     <= 1'b0;
      r_cnt     <= '0;
      r_idx     <= '0;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= 8'h00;
      o_Busy    <= 1'b0;
      o_Done    <= 1'b0;
    end else begin
      o_Tx_DV <= 1'b0;
      o_Done  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_Start) begin
            r_neg   <= i_Result[DATA_WIDTH-1];
            r_mag   <= i_Result[DATA_WIDTH-1] ? -i_Result : i_Result;
            r_bcd   <= '0;
            r_cnt   <= '0;
            o_Busy  <= 1'b1;
            r_state <= StConvert;
          end
        end
        StConvert: begin
          r_bcd <= w_bcd_next;
          r_mag <= r_mag << 1;
          r_cnt <= r_cnt + CntW'(1);
          if (r_cnt == CntW'(DATA_WIDTH - 1)) begin
            r_item  <= r_neg ? ItemSign : ItemDigit;
            r_idx   <= IdxW'(NUM_DIGITS - 1);
            r_sig   <= 1'b0;
            r_state <= StEmit;
          end
        end
        StEmit: begin
          if (w_skip) begin
            r_idx <= r_idx - IdxW'(1);
          end else if (!i_Tx_Active) begin
            o_Tx_DV   <= 1'b1;
            o_Tx_Byte <= w_byte;
            if (r_item == ItemDigit) r_sig <= 1'b1;
            r_state   <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (i_Tx_Done) begin
            r_state <= StEmit;
            case (r_item)
              ItemSign: r_item <= ItemDigit;
              ItemDigit: begin
                if (r_idx != '0) begin
                  r_idx <= r_idx - IdxW'(1);
                end else if (CrlfEn) begin
                  r_item <= ItemCr;
                end else begin
                  r_state <= StDone;
                  o_Done  <= 1'b1;
                end
              end
              ItemCr: r_item <= ItemLf;
              default: begin
                r_state <= StDone;
                o_Done  <= 1'b1;
              end
            endcase
          end
        end
        StDone: begin
          o_Busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          o_Busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_result_formatter.sv
// Scoreboard bench for uart_result_formatter with a simple transmitter model.
module tb_uart_result_formatter;

  localparam int LatMax = 16 + 5 + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] result = 16'h0000;
  logic        tx_active = 1'b0;
  logic        tx_done = 1'b0;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        busy;
  logic        done;

  uart_result_formatter dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_Start    (start),
    .i_Result   (result),
    .i_Tx_Active(tx_active),
    .i_Tx_Done  (tx_done),
    .o_Tx_DV    (tx_dv),
    .o_Tx_Byte  (tx_byte),
    .o_Busy     (busy),
    .o_Done     (done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  logic [7:0] exp_q[$];
  int cyc = 0;
  int dv_cnt = 0;
  int done_cnt = 0;
  int start_cyc = 0;
  int lat_id = 0;
  int lat_seen = 0;
  int last_txdone_cyc = -100;
  int tx_cnt = 0;
  bit hold_active = 1'b0;
  bit prev_dv = 1'b0;
  bit prev_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic push_expected(input int v);
    int m;
    int n;
    logic [7:0] dig[10];
    if (v < 0) exp_q.push_back(8'h2D);
    m = (v < 0) ? -v : v;
    n = 0;
    do begin
      dig[n] = 8'h30 + 8'(m % 10);
      m = m / 10;
      n++;
    end while (m != 0);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(dig[i]);
`ifdef UART_FMT_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  // Monitor + transmitter model, observed 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (tx_dv) begin
      chk("dv_width", {31'd0, prev_dv}, 32'd0);
      dv_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", {24'd0, tx_byte}, 32'hFFFF_FFFF);
      end else begin
        chk("byte", {24'd0, tx_byte}, {24'd0, exp_q.pop_front()});
      end
      if (lat_id != lat_seen) begin
        chk("first_dv_latency", {31'd0, (cyc - start_cyc) <= LatMax}, 32'd1);
        lat_seen = lat_id;
      end
    end
    if (done) begin
      done_cnt++;
      chk("done_busy", {31'd0, busy}, 32'd1);
      chk("done_width", {31'd0, prev_done}, 32'd0);
      chk("done_after_txdone", cyc - last_txdone_cyc, 32'd1);
    end
    if (prev_done) chk("busy_drop", {31'd0, busy}, 32'd0);
    prev_dv = tx_dv;
    prev_done = done;

    tx_done = 1'b0;
    if (hold_active) begin
      tx_active = 1'b1;
      tx_cnt = 0;
    end else if (tx_dv) begin
      tx_active = 1'b1;
      tx_cnt = 3;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_done = 1'b1;
        tx_active = 1'b0;
        last_txdone_cyc = cyc;
      end
    end else begin
      tx_active = 1'b0;
    end
  end

  task automatic start_txn(input int v, input bit lat);
    @(negedge clk);
    start = 1'b1;
    result = v[15:0];
    push_expected(v);
    if (lat) begin
      start_cyc = cyc + 1;
      lat_id++;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_dvs(input int target, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (dv_cnt >= target) ok = 1'b1;
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int base = done_cnt;
    bit got = 1'b0;
    bit busy_low = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (!busy) busy_low = 1'b1;
      if (done_cnt != base) got = 1'b1;
    end
    chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    chk({tag, "_busy_held"}, {31'd0, busy_low}, 32'd0);
    repeat (4) @(negedge clk);
    chk({tag, "_bytes_left"}, exp_q.size(), 32'd0);
    chk({tag, "_done_count"}, done_cnt - base, 32'd1);
  endtask

  initial begin
    int v;
    int base;
    repeat (3) @(negedge clk);
    chk("rst_dv", {31'd0, tx_dv}, 32'd0);
    chk("rst_byte", {24'd0, tx_byte}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    start_txn(0, 1'b1);
    wait_done("zero");
    start_txn(1234, 1'b1);
    wait_done("v1234");
    start_txn(-32768, 1'b1);
    wait_done("vmin");
    start_txn(32767, 1'b1);
    wait_done("vmax");
    start_txn(-5, 1'b1);
    wait_done("neg5");
    for (int k = 0; k < 4; k++) begin
      v = int'($urandom_range(65535)) - 32768;
      start_txn(v, 1'b1);
      wait_done("rand");
    end

    // Second start mid-transmission must be ignored.
    base = dv_cnt;
    start_txn(1234, 1'b1);
    wait_dvs(base + 2, "ign_two_dvs");
    @(negedge clk);
    start = 1'b1;
    result = 16'd1234;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore");

    // Reset while the transmitter is still busy with the second byte.
    base = dv_cnt;
    start_txn(1234, 1'b0);
    wait_dvs(base + 2, "rst_two_dvs");
    hold_active = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk("abort_dv", {31'd0, tx_dv}, 32'd0);
    chk("abort_byte", {24'd0, tx_byte}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    base = dv_cnt;
    start_txn(7, 1'b0);
    repeat (40) @(negedge clk);
    chk("held_no_dv", dv_cnt - base, 32'd0);
    hold_active = 1'b0;
    wait_done("after_rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

endmodule

// File: doc/uart_result_formatter.md
Name: uart_result_formatter

Overview:
- Upstream feeder for the UART transmitter in the calculator.
- Takes one signed binary calculator result, converts it to ASCII decimal with sign and leading-zero suppression, and streams the bytes to the transmitter one at a time.
- Uses the transmitter's DV/Active/Done handshake.
- Sits between the ALU result register and the UART TX stage.

Parameters:
- DATA_WIDTH, 16, width of signed two's-complement input result.
- NUM_DIGITS, 5, BCD digit count. Must satisfy 10^NUM_DIGITS > 2^(DATA_WIDTH-1).

Ports:
- i_Clock  input  1  system clock.
- i_Reset  input  1  synchronous, active-high reset.
- i_Start  input  1  single-cycle request to format and send i_Result.
- i_Result  input  DATA_WIDTH  signed result, sampled only on an accepted i_Start.
- i_Tx_Active  input  1  transmitter busy flag.
- i_Tx_Done  input  1  transmitter one-cycle byte-complete pulse.
- o_Tx_DV  output  1  one-cycle byte-valid strobe to the transmitter.
- o_Tx_Byte  output  8  ASCII byte to transmit; valid while o_Tx_DV is high.
- o_Busy  output  1  high from accepted start until the o_Done cycle, inclusive.
- o_Done  output  1  one-cycle pulse after the last byte completes.

Behaviour:
- Reset: all outputs 0; state IDLE; internal registers cleared. Reset overrides any in-flight operation; no further o_Tx_DV is issued for the aborted result.
- IDLE:
  - i_Start high → latch magnitude and sign, set o_Busy, go to CONVERT.
  - i_Start while not IDLE is ignored; no queueing.
- Magnitude:
  - Computed in DATA_WIDTH unsigned bits.
  - -2^(DATA_WIDTH-1) must yield the correct magnitude (e.g. 32768 for 16 bits).
- CONVERT: iterative double-dabble, one shift per cycle, exactly DATA_WIDTH cycles, producing NUM_DIGITS BCD digits.
- Byte order: '-' (0x2D) only if negative; digits most-significant first; then terminator (see optional feature).
- Leading-zero suppression:
  - Leading zero digits are skipped.
  - Value 0 emits a single '0' (0x30).
  - Digit d is sent as 0x30+d.
- Per-byte handshake (EMIT → WAIT_DONE):
  - EMIT: when i_Tx_Active is low, drive o_Tx_Byte and assert o_Tx_DV for exactly one cycle, then go to WAIT_DONE.
  - EMIT holds (no DV) while i_Tx_Active is high. This covers a transmitter still busy after a formatter reset.
  - WAIT_DONE: on i_Tx_Done, advance to the next byte. The next o_Tx_DV may be issued in the cycle after i_Tx_Done, because the transmitter is back in idle by then.
  - o_Tx_Byte holds its value from the DV cycle until the next DV.
- DONE: after i_Tx_Done of the final byte, o_Done pulses for one cycle, o_Busy drops the following cycle, return to IDLE.
- i_Tx_Done seen outside WAIT_DONE is ignored.
- Latency: first o_Tx_DV no later than DATA_WIDTH + NUM_DIGITS + 3 cycles after the start cycle, given i_Tx_Active low.
- States: IDLE, CONVERT, EMIT, WAIT_DONE, DONE.
- Default case recovers to IDLE.

Optional Feature:
- Macro: UART_FMT_CRLF_EN.
- Defined: after the last digit, send CR (0x0D) then LF (0x0A) through the same handshake before o_Done.
- Undefined: o_Done follows the last digit's i_Tx_Done directly; no terminator bytes.
- Bench expectations below assume the macro is defined unless noted.

Test Plan:
- Result 0, Start → bytes 0x30,0x0D,0x0A; one o_Done pulse; each o_Tx_DV exactly one cycle wide.
- Result 1234 → 0x31,0x32,0x33,0x34,0x0D,0x0A; no leading '0'; no sign byte.
- Result -32768 (0x8000) → 0x2D,0x33,0x32,0x37,0x36,0x38,0x0D,0x0A. Also result 32767 → "32767\r\n".
- Start for 1234 issued again mid-transmission → ignored; only one "1234\r\n" sequence; o_Busy stays high throughout.
- Reset asserted after the 2nd byte's DV while i_Tx_Active is high → outputs 0 next cycle. A new Start for 7 issues no DV until i_Tx_Active falls, then sends "7\r\n".
- UART_FMT_CRLF_EN undefined, result -5 → bytes 0x2D,0x35 only; o_Done one cycle after the second i_Tx_Done.
